// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_add_pkg

// File: rtl/full_half_add_1bit.sv
// One-bit full adder built from two half adders; the only adder in the datapath.
module full_half_add_1bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum_c,
   output logic o_cout_c
);

   logic ha0_sum;
   logic ha0_carry;
   logic ha1_carry;

   always_comb begin
      ha0_sum   = i_a ^ i_b;
      ha0_carry = i_a & i_b;
      ha1_carry = ha0_sum & i_cin;
      o_sum_c   = ha0_sum ^ i_cin;
      o_cout_c  = ha0_carry | ha1_carry;
   end

endmodule : full_half_add_1bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts A/B/cin, adds one bit per cycle LSB first, and
// presents the WIDTH-bit sum and carry-out under a valid/ready handshake.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_busy
);

   localparam int unsigned         CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;

   logic               fa_sum;
   logic               fa_cout;

   full_half_add_1bit u_fa (
      .i_a      (a_q[0]),
      .i_b      (b_q[0]),
      .i_cin    (carry_q),
      .o_sum_c  (fa_sum),
      .o_cout_c (fa_cout)
   );

   // Next-state and datapath; status flags are registered from the next state.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (i_valid && ready_q) begin
               a_d     = i_a;
               b_d     = i_b;
               carry_d = i_cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
      busy_d  = (state_d == RUN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_busy  = busy_q;
   assign o_sum   = res_q;
   assign o_cout  = carry_q;

endmodule : serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..64.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_valid  input  1  request carries valid operands.
REQ-005 SHALL have port o_ready  output  1  controller can accept a request.
REQ-006 SHALL have port i_a  input  WIDTH  operand A.
REQ-007 SHALL have port i_b  input  WIDTH  operand B.
REQ-008 SHALL have port i_cin  input  1  carry-in for bit 0.
REQ-009 SHALL have port o_valid  output  1  result available.
REQ-010 SHALL have port i_ready  input  1  consumer accepts result.
REQ-011 SHALL have port o_sum  output  WIDTH  sum, (A+B+cin) mod 2^WIDTH.
REQ-012 SHALL have port o_cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port o_busy  output  1  high while in RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; one adder bit per cycle through one shared 1-bit full adder.
REQ-015 IDLE: o_ready=1, o_valid=0, o_busy=0; on i_valid&&o_ready, capture i_a, i_b into shift registers, load carry register with i_cin, clear bit counter, go RUN.
REQ-016 RUN: o_ready=0, o_busy=1; each cycle feed LSBs of A/B shift registers and carry register to full adder, shift sum bit into result register from MSB side, store adder carry, shift A/B right, increment counter.
REQ-017 RUN SHALL exit to DONE on the cycle counter==WIDTH-1 is processed; exactly WIDTH RUN cycles per operation.
REQ-018 Latency: request accepted at edge k -> o_valid=1 after edge k+WIDTH; o_sum/o_cout valid and final at that point.
REQ-019 DONE: o_valid=1, o_ready=0; o_sum and o_cout SHALL hold stable until o_valid&&i_ready.
REQ-020 On o_valid&&i_ready in DONE SHALL go IDLE; o_ready=1 the following cycle (no same-cycle accept in DONE).
REQ-021 i_valid and operand changes during RUN or DONE SHALL be ignored; captured operands unaffected.
REQ-022 i_ready while not in DONE SHALL have no effect.
REQ-023 Bit counter width SHALL be $clog2(WIDTH); no wrap beyond WIDTH-1.
REQ-024 Unreachable FSM encodings SHALL return to IDLE next cycle.

Reset
REQ-025 i_rst_n low SHALL immediately force IDLE, o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_cout=0, counter, shift and carry registers 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result presented after release.
REQ-027 First request accepted on the first rising edge with i_rst_n high and i_valid high.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and default WIDTH constant.
REQ-029 Controller SHALL instantiate exactly one full_half_add_1bit as the bit datapath; no other adder logic.

Verification
REQ-030 WIDTH=8: A=0x3C, B=0x0F, cin=0 -> o_sum=0x4B, o_cout=0, o_valid exactly 8 cycles after accept.
REQ-031 A=0xFF, B=0x01, cin=0 -> o_sum=0x00, o_cout=1; A=0x5A, B=0xA5, cin=1 -> o_sum=0x00, o_cout=1.
REQ-032 i_ready held low 5 cycles in DONE -> o_valid, o_sum, o_cout stable all 5 cycles; o_ready rises cycle after handshake.
REQ-033 i_valid pulsed with A=0x11, B=0x22 during RUN of 0x3C+0x0F -> result still 0x4B, second request not taken.
REQ-034 i_rst_n low at RUN cycle 4 -> outputs at reset values immediately; after release, 0x01+0x01 cin=0 -> 0x02, cout=0.
REQ-035 Random back-to-back 1000 operations, i_valid/i_ready randomly toggled -> every result matches reference A+B+cin.
